// File: rtl/ddr3_axi_wrcmd.sv
// AXI4 AW front-end: splits each burst into BL8 write requests for the DDR3 controller, one B per burst.
// Optional WRAP burst support is enabled by defining DDR3_AXI_WRAP_BURST_EN.
module ddr3_axi_wrcmd #(
    parameter int ADDRS = 25,
    parameter int REQID = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             axi_awvalid_i,
    output logic             axi_awready_o,
    input  logic [REQID-1:0] axi_awid_i,
    input  logic [ADDRS:0]   axi_awaddr_i,
    input  logic [7:0]       axi_awlen_i,
    input  logic [1:0]       axi_awburst_i,
    output logic             axi_bvalid_o,
    input  logic             axi_bready_i,
    output logic [REQID-1:0] axi_bid_o,
    output logic [1:0]       axi_bresp_o,
    output logic             mem_wrreq_o,
    output logic             mem_wrlst_o,
    input  logic             mem_wrack_i,
    input  logic             mem_wrerr_i,
    output logic [REQID-1:0] mem_wrtid_o,
    output logic [ADDRS-1:0] mem_wradr_o
);

    // state | meaning
    // IDLE  | awready high, waiting for an AW handshake
    // REQ   | presenting BL8 write requests until the last chunk is acked
    // RESP  | bvalid high, waiting for bready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t           r_state, w_state_nxt;
    logic             r_awready, w_awready_nxt;
    logic             r_bvalid, w_bvalid_nxt;
    logic [REQID-1:0] r_bid, w_bid_nxt;
    logic [1:0]       r_bresp, w_bresp_nxt;
    logic             r_wrreq, w_wrreq_nxt;
    logic             r_wrlst, w_wrlst_nxt;
    logic [REQID-1:0] r_wrtid, w_wrtid_nxt;
    logic [ADDRS-1:0] r_wradr, w_wradr_nxt;
    logic [ADDRS-1:0] r_mask, w_mask_nxt;
    logic [6:0]       r_count, w_count_nxt;
    logic             r_err, w_err_nxt;

    logic             w_aw_hs;
    logic             w_burst_ok;
    logic             w_legal;
    logic [ADDRS-1:0] w_mask_acc;
    logic [ADDRS-1:0] w_adr_inc;

    assign w_aw_hs = axi_awvalid_i & r_awready;

    // r_mask selects the address bits that wrap; all ones means a plain incrementing burst.
    always_comb begin
        w_burst_ok = 1'b0;
        w_mask_acc = '1;
        case (axi_awburst_i)
            2'b01: w_burst_ok = 1'b1;
`ifdef DDR3_AXI_WRAP_BURST_EN
            2'b10: begin
                w_burst_ok = (axi_awlen_i == 8'd3) || (axi_awlen_i == 8'd7) ||
                             (axi_awlen_i == 8'd15);
                w_mask_acc = {{(ADDRS-5){1'b0}}, axi_awlen_i[3:0], 1'b1};
            end
`endif
            default: w_burst_ok = 1'b0;
        endcase
    end

    assign w_legal = (axi_awaddr_i[3:0] == 4'd0) && (axi_awlen_i[1:0] == 2'b11) && w_burst_ok;

    assign w_adr_inc = (r_wradr & ~r_mask) |
                       ((r_wradr + {{(ADDRS-4){1'b0}}, 4'd8}) & r_mask);

    always_comb begin
        w_state_nxt = r_state;
        w_bvalid_nxt = r_bvalid;
        w_bid_nxt = r_bid;
        w_bresp_nxt = r_bresp;
        w_wrreq_nxt = r_wrreq;
        w_wrlst_nxt = r_wrlst;
        w_wrtid_nxt = r_wrtid;
        w_wradr_nxt = r_wradr;
        w_mask_nxt = r_mask;
        w_count_nxt = r_count;
        w_err_nxt = r_err;
        case (r_state)
            IDLE: begin
                if (w_aw_hs) begin
                    w_wrtid_nxt = axi_awid_i;
                    w_wradr_nxt = axi_awaddr_i[ADDRS:1];
                    w_mask_nxt = w_mask_acc;
                    w_count_nxt = {1'b0, axi_awlen_i[7:2]} + 7'd1;
                    if (w_legal) begin
                        w_state_nxt = REQ;
                        w_wrreq_nxt = 1'b1;
                        w_wrlst_nxt = (axi_awlen_i[7:2] == 6'd0);
                    end else begin
                        w_state_nxt = RESP;
                        w_err_nxt = 1'b1;
                        w_bvalid_nxt = 1'b1;
                        w_bid_nxt = axi_awid_i;
                        w_bresp_nxt = RESP_SLVERR;
                    end
                end
            end
            REQ: begin
                if (mem_wrack_i) begin
                    w_err_nxt = r_err | mem_wrerr_i;
                    if (r_count == 7'd1) begin
                        w_state_nxt = RESP;
                        w_wrreq_nxt = 1'b0;
                        w_wrlst_nxt = 1'b0;
                        w_bvalid_nxt = 1'b1;
                        w_bid_nxt = r_wrtid;
                        w_bresp_nxt = (r_err | mem_wrerr_i) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_count_nxt = r_count - 7'd1;
                        w_wradr_nxt = w_adr_inc;
                        w_wrlst_nxt = (r_count == 7'd2);
                    end
                end
            end
            RESP: begin
                if (axi_bready_i) begin
                    w_state_nxt = IDLE;
                    w_bvalid_nxt = 1'b0;
                    w_bresp_nxt = RESP_OKAY;
                    w_err_nxt = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_awready_nxt = (w_state_nxt == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_awready <= 1'b0;
            r_bvalid <= 1'b0;
            r_bid <= '0;
            r_bresp <= RESP_OKAY;
            r_wrreq <= 1'b0;
            r_wrlst <= 1'b0;
            r_wrtid <= '0;
            r_wradr <= '0;
            r_mask <= '1;
            r_count <= '0;
            r_err <= 1'b0;
        end else begin
            r_awready <= w_awready_nxt;
            r_bvalid <= w_bvalid_nxt;
            r_bid <= w_bid_nxt;
            r_bresp <= w_bresp_nxt;
            r_wrreq <= w_wrreq_nxt;
            r_wrlst <= w_wrlst_nxt;
            r_wrtid <= w_wrtid_nxt;
            r_wradr <= w_wradr_nxt;
            r_mask <= w_mask_nxt;
            r_count <= w_count_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign axi_awready_o = r_awready;
    assign axi_bvalid_o = r_bvalid;
    assign axi_bid_o = r_bid;
    assign axi_bresp_o = r_bresp;
    assign mem_wrreq_o = r_wrreq;
    assign mem_wrlst_o = r_wrlst;
    assign mem_wrtid_o = r_wrtid;
    assign mem_wradr_o = r_wradr;

endmodule

// File: tb/tb_ddr3_axi_wrcmd.sv
// Directed bench for ddr3_axi_wrcmd: burst vector table plus reset-mid-burst and stray-ack sequences.
module tb_ddr3_axi_wrcmd;
    localparam int ADDRS = 25;
    localparam int REQID = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             axi_awvalid_i = 1'b0;
    logic             axi_awready_o;
    logic [REQID-1:0] axi_awid_i = '0;
    logic [ADDRS:0]   axi_awaddr_i = '0;
    logic [7:0]       axi_awlen_i = '0;
    logic [1:0]       axi_awburst_i = '0;
    logic             axi_bvalid_o;
    logic             axi_bready_i = 1'b0;
    logic [REQID-1:0] axi_bid_o;
    logic [1:0]       axi_bresp_o;
    logic             mem_wrreq_o;
    logic             mem_wrlst_o;
    logic             mem_wrack_i = 1'b0;
    logic             mem_wrerr_i = 1'b0;
    logic [REQID-1:0] mem_wrtid_o;
    logic [ADDRS-1:0] mem_wradr_o;

    always #5 clock = ~clock;

    ddr3_axi_wrcmd #(.ADDRS(ADDRS), .REQID(REQID)) dut (
        .clock(clock),
        .reset(reset),
        .axi_awvalid_i(axi_awvalid_i),
        .axi_awready_o(axi_awready_o),
        .axi_awid_i(axi_awid_i),
        .axi_awaddr_i(axi_awaddr_i),
        .axi_awlen_i(axi_awlen_i),
        .axi_awburst_i(axi_awburst_i),
        .axi_bvalid_o(axi_bvalid_o),
        .axi_bready_i(axi_bready_i),
        .axi_bid_o(axi_bid_o),
        .axi_bresp_o(axi_bresp_o),
        .mem_wrreq_o(mem_wrreq_o),
        .mem_wrlst_o(mem_wrlst_o),
        .mem_wrack_i(mem_wrack_i),
        .mem_wrerr_i(mem_wrerr_i),
        .mem_wrtid_o(mem_wrtid_o),
        .mem_wradr_o(mem_wradr_o)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [ADDRS:0]        addr;
        logic [7:0]            len;
        logic [1:0]            burst;
        logic [REQID-1:0]      id;
        int                    nreq;
        logic [3:0][ADDRS-1:0] adrs;
        int                    ack_dly;
        int                    err_chunk;
        int                    bdly;
        logic [1:0]            bresp;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic [ADDRS:0] addr, input logic [7:0] len,
                                input logic [1:0] burst, input logic [REQID-1:0] id,
                                input int nreq, input logic [ADDRS-1:0] a0,
                                input logic [ADDRS-1:0] a1, input logic [ADDRS-1:0] a2,
                                input logic [ADDRS-1:0] a3, input int ack_dly,
                                input int err_chunk, input int bdly, input logic [1:0] bresp);
        vec_t v;
        v.addr = addr;
        v.len = len;
        v.burst = burst;
        v.id = id;
        v.nreq = nreq;
        v.adrs = {a3, a2, a1, a0};
        v.ack_dly = ack_dly;
        v.err_chunk = err_chunk;
        v.bdly = bdly;
        v.bresp = bresp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered and left at a negedge with the DUT idle and awready high.
    task automatic run_vec(input int vi, input vec_t v);
        chk($sformatf("v%0d awready idle", vi), axi_awready_o, 1);
        axi_awvalid_i = 1'b1;
        axi_awaddr_i = v.addr;
        axi_awlen_i = v.len;
        axi_awburst_i = v.burst;
        axi_awid_i = v.id;
        @(negedge clock);
        axi_awvalid_i = 1'b0;
        chk($sformatf("v%0d awready busy", vi), axi_awready_o, 0);
        if (v.nreq == 0) begin
            chk($sformatf("v%0d illegal bvalid", vi), axi_bvalid_o, 1);
            chk($sformatf("v%0d illegal wrreq", vi), mem_wrreq_o, 0);
        end
        for (int i = 0; i < v.nreq; i++) begin
            for (int d = 0; d < v.ack_dly; d++) begin
                chk($sformatf("v%0d c%0d hold wrreq", vi, i), mem_wrreq_o, 1);
                chk($sformatf("v%0d c%0d hold wradr", vi, i), mem_wradr_o, v.adrs[i]);
                chk($sformatf("v%0d c%0d hold wrtid", vi, i), mem_wrtid_o, v.id);
                @(negedge clock);
            end
            chk($sformatf("v%0d c%0d wrreq", vi, i), mem_wrreq_o, 1);
            chk($sformatf("v%0d c%0d wradr", vi, i), mem_wradr_o, v.adrs[i]);
            chk($sformatf("v%0d c%0d wrlst", vi, i), mem_wrlst_o, (i == v.nreq - 1));
            chk($sformatf("v%0d c%0d wrtid", vi, i), mem_wrtid_o, v.id);
            chk($sformatf("v%0d c%0d bvalid", vi, i), axi_bvalid_o, 0);
            mem_wrack_i = 1'b1;
            mem_wrerr_i = (i == v.err_chunk);
            @(negedge clock);
            mem_wrack_i = 1'b0;
            mem_wrerr_i = 1'b0;
        end
        if (v.nreq > 0) begin
            chk($sformatf("v%0d wrreq after last", vi), mem_wrreq_o, 0);
            chk($sformatf("v%0d bvalid after last", vi), axi_bvalid_o, 1);
        end
        for (int d = 0; d < v.bdly; d++) begin
            chk($sformatf("v%0d bwait bvalid", vi), axi_bvalid_o, 1);
            chk($sformatf("v%0d bwait bid", vi), axi_bid_o, v.id);
            chk($sformatf("v%0d bwait bresp", vi), axi_bresp_o, v.bresp);
            chk($sformatf("v%0d bwait awready", vi), axi_awready_o, 0);
            chk($sformatf("v%0d bwait wrreq", vi), mem_wrreq_o, 0);
            @(negedge clock);
        end
        chk($sformatf("v%0d bvalid", vi), axi_bvalid_o, 1);
        chk($sformatf("v%0d bid", vi), axi_bid_o, v.id);
        chk($sformatf("v%0d bresp", vi), axi_bresp_o, v.bresp);
        axi_bready_i = 1'b1;
        @(negedge clock);
        axi_bready_i = 1'b0;
        chk($sformatf("v%0d bvalid done", vi), axi_bvalid_o, 0);
        chk($sformatf("v%0d awready after B", vi), axi_awready_o, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " awready"}, axi_awready_o, 0);
        chk({tag, " bvalid"}, axi_bvalid_o, 0);
        chk({tag, " bresp"}, axi_bresp_o, 0);
        chk({tag, " bid"}, axi_bid_o, 0);
        chk({tag, " wrreq"}, mem_wrreq_o, 0);
        chk({tag, " wrlst"}, mem_wrlst_o, 0);
        chk({tag, " wrtid"}, mem_wrtid_o, 0);
        chk({tag, " wradr"}, mem_wradr_o, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = mk(26'h40, 8'd7, 2'b01, 4'd2, 2, 25'h20, 25'h28, 25'h0, 25'h0, 1, -1, 0, 2'b00);
        vecs[1] = mk(26'h0, 8'd3, 2'b01, 4'd5, 1, 25'h0, 25'h0, 25'h0, 25'h0, 5, -1, 0, 2'b00);
        vecs[2] = mk(26'h08, 8'd3, 2'b01, 4'd1, 0, 25'h0, 25'h0, 25'h0, 25'h0, 0, -1, 0, 2'b10);
        vecs[3] = mk(26'h0, 8'd5, 2'b01, 4'd3, 0, 25'h0, 25'h0, 25'h0, 25'h0, 0, -1, 0, 2'b10);
        vecs[4] = mk(26'h0, 8'd3, 2'b00, 4'd4, 0, 25'h0, 25'h0, 25'h0, 25'h0, 0, -1, 0, 2'b10);
        vecs[5] = mk(26'h100, 8'd11, 2'b01, 4'd6, 3, 25'h80, 25'h88, 25'h90, 25'h0, 0, 1, 0, 2'b10);
`ifdef DDR3_AXI_WRAP_BURST_EN
        vecs[6] = mk(26'h30, 8'd15, 2'b10, 4'd7, 4, 25'h18, 25'h00, 25'h08, 25'h10, 0, -1, 0, 2'b00);
`else
        vecs[6] = mk(26'h30, 8'd15, 2'b10, 4'd7, 0, 25'h0, 25'h0, 25'h0, 25'h0, 0, -1, 0, 2'b10);
`endif
        vecs[7] = mk(26'h80, 8'd3, 2'b01, 4'd9, 1, 25'h40, 25'h0, 25'h0, 25'h0, 0, -1, 4, 2'b00);
        vecs[8] = mk(26'h0, 8'd3, 2'b11, 4'd10, 0, 25'h0, 25'h0, 25'h0, 25'h0, 0, -1, 1, 2'b10);
        vecs[9] = mk(26'h3FFFFF0, 8'd7, 2'b01, 4'd11, 2, 25'h1FFFFF8, 25'h0, 25'h0, 25'h0, 0, -1, 0, 2'b00);

        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);
        chk("awready after reset", axi_awready_o, 1);

        for (int vi = 0; vi < 10; vi++) begin
            run_vec(vi, vecs[vi]);
        end

        // Reset after the first ack of a 4-chunk burst drops the burst without a B response.
        axi_awvalid_i = 1'b1;
        axi_awaddr_i = 26'h0;
        axi_awlen_i = 8'd15;
        axi_awburst_i = 2'b01;
        axi_awid_i = 4'd12;
        @(negedge clock);
        axi_awvalid_i = 1'b0;
        chk("rst seq wrreq", mem_wrreq_o, 1);
        chk("rst seq wradr0", mem_wradr_o, 25'h0);
        mem_wrack_i = 1'b1;
        @(negedge clock);
        mem_wrack_i = 1'b0;
        chk("rst seq wradr1", mem_wradr_o, 25'h8);
        reset = 1'b1;
        @(negedge clock);
        chk_all_zero("midreset");
        reset = 1'b0;
        @(negedge clock);
        chk("rst seq awready", axi_awready_o, 1);
        axi_bready_i = 1'b1;
        for (int d = 0; d < 4; d++) begin
            chk("rst seq no bvalid", axi_bvalid_o, 0);
            chk("rst seq no wrreq", mem_wrreq_o, 0);
            @(negedge clock);
        end
        axi_bready_i = 1'b0;

        // An erroring ack while idle must not touch the FSM or the sticky error.
        mem_wrack_i = 1'b1;
        mem_wrerr_i = 1'b1;
        @(negedge clock);
        mem_wrack_i = 1'b0;
        mem_wrerr_i = 1'b0;
        chk("stray ack wrreq", mem_wrreq_o, 0);
        chk("stray ack bvalid", axi_bvalid_o, 0);
        chk("stray ack awready", axi_awready_o, 1);
        run_vec(99, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddr3_axi_wrcmd.md
# ddr3_axi_wrcmd

AXI4 write-address front-end for the DDR3 memory controller. Accepts AW bursts, splits each into BL8-sized write requests, and drives the controller FSM's write-request port (`mem_wr*`) with the `wrlst` framing that port expects. Returns one B response per burst once the last chunk has been acknowledged. Sits directly upstream of the controller FSM; write data travels separately through the datapath.

## Interface
Parameters:
- `ADDRS`, 25: controller address width in 16-bit DDR3 word units (COL+ROW+3-1).
- `REQID`, 4: transaction ID width.

Ports:
- `clock` in, 1: system clock; one clock domain.
- `reset` in, 1: synchronous, active-high reset.
- `axi_awvalid_i` in, 1: AW valid.
- `axi_awready_o` out, 1: AW ready.
- `axi_awid_i` in, REQID: AW ID.
- `axi_awaddr_i` in, ADDRS+1: byte address.
- `axi_awlen_i` in, 8: beats minus 1; each beat is 32 bits.
- `axi_awburst_i` in, 2: burst type; 01 INCR, 10 WRAP.
- `axi_bvalid_o` out, 1: B valid.
- `axi_bready_i` in, 1: B ready.
- `axi_bid_o` out, REQID: B ID.
- `axi_bresp_o` out, 2: 00 OKAY, 10 SLVERR.
- `mem_wrreq_o` out, 1: write request to the controller.
- `mem_wrlst_o` out, 1: final chunk of the burst.
- `mem_wrack_i` in, 1: one-cycle acceptance pulse from the controller.
- `mem_wrerr_i` in, 1: error flag, valid only when `mem_wrack_i` is high.
- `mem_wrtid_o` out, REQID: ID of the request.
- `mem_wradr_o` out, ADDRS: word address, BL8-aligned (low 3 bits zero).

## Operation
- FSM states: `IDLE`, `REQ`, `RESP`.
- `IDLE`: `axi_awready_o`=1. On `awvalid&awready`:
  - Latch the ID.
  - Chunk count = `awlen[7:2]`+1.
  - Start address = `awaddr[ADDRS:1]`.
- Legality check, made at acceptance:
  - `awaddr[3:0]`==0.
  - `awlen[1:0]`==2'b11.
  - `awburst` is a supported type.
- Legal burst: go to `REQ`. Illegal burst: set error, issue no memory requests, go to `RESP`.
- `REQ`: `mem_wrreq_o`=1, with `mem_wrlst_o` = (remaining chunks == 1).
  - On `mem_wrack_i` with chunks remaining: address += 8 and count -= 1, both in the same cycle. `mem_wrreq_o` stays high and the new address is presented the next cycle.
  - On `mem_wrack_i` for the last chunk: drop `mem_wrreq_o` and go to `RESP`.
  - `mem_wrerr_i` seen with any ack sets a sticky error.
- `RESP`: `axi_bvalid_o`=1, `bid` = latched ID, `bresp` = SLVERR if the sticky error is set, else OKAY. On `bready`, clear the error and go to `IDLE`.
- Address increment is modulo 2^ADDRS; it wraps silently at the top of memory.
- One burst outstanding at a time. `awready` is low in `REQ` and `RESP`.
- `mem_wrreq_o`, `mem_wrlst_o`, `mem_wrtid_o` and `mem_wradr_o` are held stable while the request waits for its ack.

## Timing
- Reset values: `axi_awready_o`=0, `axi_bvalid_o`=0, `axi_bresp_o`=0, `axi_bid_o`=0, `mem_wrreq_o`=0, `mem_wrlst_o`=0, `mem_wrtid_o`=0, `mem_wradr_o`=0. The FSM resets to `IDLE`.
- `axi_awready_o` rises the first cycle after `reset` deasserts.
- All outputs are registered.
- AW accepted at edge N:
  - `mem_wrreq_o` is high from N+1.
  - An illegal burst gives `bvalid` at N+1.
- Last ack at edge M: `bvalid` at M+1, `mem_wrreq_o` low at M+1.
- After the B handshake at edge K: `awready` at K+1. Minimum AW-to-AW spacing is therefore chunks+3 cycles when acks are immediate.
- An ack seen outside `REQ` is ignored.
- `reset` mid-burst: all state and outputs return to reset values on the next edge. Outstanding chunks are dropped and no B response is produced.

## Configuration
- Macro: `DDR3_AXI_WRAP_BURST_EN`.
- Defined:
  - WRAP bursts with `awlen` in {3, 7, 15} are legal.
  - Wrap boundary = (awlen+1)*2 words.
  - Chunk address = base | ((start + 8*i) mod boundary), where base is the start address with its low log2(boundary) bits cleared.
  - WRAP with any other `awlen` is illegal and returns SLVERR.
- Undefined: any WRAP burst is illegal and returns SLVERR with no memory requests. INCR behaviour is identical in both builds.
- FIXED (00) and reserved (11) bursts are always illegal.

## Test plan
- INCR, awaddr=0x40, awlen=7, id=2, ack 1 cycle after each req:
  - Two requests: adr 0x20 with wrlst=0, then adr 0x28 with wrlst=1.
  - B: bid=2, bresp=OKAY.
- INCR, awaddr=0, awlen=3, controller ack delayed 5 cycles:
  - req/adr/tid held stable for 5 cycles.
  - Single request with wrlst=1; OKAY.
- Illegal bursts, each with no `mem_wrreq_o` pulse:
  - awaddr=0x08 → SLVERR.
  - awlen=5 → SLVERR.
  - awburst=00 → SLVERR.
- INCR, awlen=11, `mem_wrerr_i`=1 on the second ack:
  - All three chunks are still issued.
  - bresp=SLVERR.
- WRAP, awaddr=0x30, awlen=15 (boundary 32 words):
  - With macro defined: adrs 0x18, 0x00, 0x08, 0x10; OKAY.
  - With macro undefined: SLVERR and no requests.
- `reset` asserted after the first ack of a 4-chunk burst:
  - Next cycle all outputs are 0 and the FSM is in `IDLE`.
  - `awready`=1 one cycle after `reset` is released.
  - B response: `bvalid` stays low; the interrupted burst gets no B response.
- `bready` held low for 4 cycles:
  - `bvalid`, `bid` and `bresp` are held.
  - `awready` stays low until the handshake completes.
